ebc_readout_seq: RTL and testbench



---
 rtl/ebc_readout_seq.sv | 181 ++++++++++++++++++
 tb/tb_ebc_readout_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebc_readout_seq.sv
// EBC readout sequencer: round-robin row grant, column snapshot, one event per set column.
// Optional stall counter output is built when EBC_SEQ_STALL_CNT_EN is defined.

module ebc_readout_seq #(
    parameter  int ROWS = 8,
    parameter  int COLS = 8,
    parameter  int TS_W = 16,
    localparam int X_W  = $clog2(COLS),
    localparam int Y_W  = $clog2(ROWS)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [ROWS*COLS-1:0] pix_req_i,
    input  logic                 evt_ready_i,
    output logic                 evt_valid_o,
    output logic [X_W-1:0]       evt_x_o,
    output logic [Y_W-1:0]       evt_y_o,
    output logic [TS_W-1:0]      evt_ts_o,
    output logic [ROWS*COLS-1:0] pix_ack_o,
    output logic                 row_release_o,
    output logic                 busy_o
`ifdef EBC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt_o
`endif
);

    localparam int A_W = $clog2(ROWS*COLS);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SCAN, S_EMIT} state_t;

    state_t          r_state;
    logic [Y_W-1:0]  r_last_row;
    logic [Y_W-1:0]  r_sel_row;
    logic [COLS-1:0] r_col_snap;
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_grp_ts;
    logic            r_evt_valid;
    logic [X_W-1:0]  r_evt_x;
    logic [Y_W-1:0]  r_evt_y;
    logic [TS_W-1:0] r_evt_ts;
    logic            r_release;

    logic [ROWS-1:0] w_row_req;
    logic [Y_W-1:0]  w_sel_row;
    logic [Y_W-1:0]  w_idx;
    logic            w_found;
    logic [COLS-1:0] w_sel_slice;
    logic [X_W-1:0]  w_low_col;
    logic            w_handshake;
    logic [A_W-1:0]  w_ack_idx;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            w_row_req[r] = |pix_req_i[r*COLS +: COLS];
        end
    end

    // Round-robin search starting just after the last granted row, with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_sel_row = r_last_row;
        w_idx     = r_last_row;
        w_found   = 1'b0;
        for (int k = 0; k < ROWS; k++) begin
            w_idx = (w_idx == Y_W'(ROWS-1)) ? '0 : w_idx + 1'b1;
            if (w_row_req[w_idx] && !w_found) begin
                w_sel_row = w_idx;
                w_found   = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_slice = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (Y_W'(r) == w_sel_row) begin
                w_sel_slice = pix_req_i[r*COLS +: COLS];
            end
        end
    end

    always_comb begin
        w_low_col = '0;
        for (int c = COLS-1; c >= 0; c--) begin
            if (r_col_snap[c]) begin
                w_low_col = X_W'(c);
            end
        end
    end

    // Acknowledge is combinational so it lands exactly in the handshake cycle.
    assign w_handshake = r_evt_valid & evt_ready_i;
    assign w_ack_idx   = A_W'(int'(r_evt_y) * COLS + int'(r_evt_x));
    assign pix_ack_o   = {{(ROWS*COLS-1){1'b0}}, w_handshake} << w_ack_idx;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_last_row  <= Y_W'(ROWS-1);
            r_sel_row   <= '0;
            r_col_snap  <= '0;
            r_ts_cnt    <= '0;
            r_grp_ts    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_x     <= '0;
            r_evt_y     <= '0;
            r_evt_ts    <= '0;
            r_release   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            r_ts_cnt  <= r_ts_cnt + 1'b1;
            r_release <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable_i && (|w_row_req)) begin
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_sel_row  <= w_sel_row;
                    r_col_snap <= w_sel_slice;
                    r_grp_ts   <= r_ts_cnt;
                    r_last_row <= w_sel_row;
                    r_state    <= S_SCAN;
                end
                S_SCAN: begin
                    if (!enable_i) begin
                        r_col_snap <= '0;
                        r_state    <= S_IDLE;
                    end else if (r_col_snap == '0) begin
                        r_release <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_evt_x     <= w_low_col;
                        r_evt_y     <= r_sel_row;
                        r_evt_ts    <= r_grp_ts;
                        r_col_snap  <= r_col_snap & (r_col_snap - 1'b1);
                        r_evt_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (evt_ready_i) begin
                        r_evt_valid <= 1'b0;
                        if (enable_i) begin
                            r_state <= S_SCAN;
                        end else begin
                            r_col_snap <= '0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign evt_valid_o   = r_evt_valid;
    assign evt_x_o       = r_evt_x;
    assign evt_y_o       = r_evt_y;
    assign evt_ts_o      = r_evt_ts;
    assign row_release_o = r_release;
    assign busy_o        = (r_state != S_IDLE);

`ifdef EBC_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
        end else if (r_evt_valid && !evt_ready_i && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ebc_readout_seq.sv
// Self-checking bench for ebc_readout_seq: directed scenarios plus randomized request rounds
// checked against a transaction-level round-robin model.

module tb_ebc_readout_seq;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int TS_W = 16;
    localparam int N    = ROWS * COLS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            ready = 1'b1;
    logic [N-1:0]    req = '0;

    logic            evt_valid;
    logic [2:0]      evt_x;
    logic [2:0]      evt_y;
    logic [TS_W-1:0] evt_ts;
    logic [N-1:0]    pix_ack;
    logic            row_release;
    logic            busy;
`ifdef EBC_SEQ_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int tcount;
    int m_last_row;

    logic [N-1:0] rnd_req;
    int           rnd_rows;
    int           t0;

    ebc_readout_seq #(.ROWS(ROWS), .COLS(COLS), .TS_W(TS_W)) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .enable_i      (en),
        .pix_req_i     (req),
        .evt_ready_i   (ready),
        .evt_valid_o   (evt_valid),
        .evt_x_o       (evt_x),
        .evt_y_o       (evt_y),
        .evt_ts_o      (evt_ts),
        .pix_ack_o     (pix_ack),
        .row_release_o (row_release),
        .busy_o        (busy)
`ifdef EBC_SEQ_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference time base: cycles since reset release, as the free-running timestamp.
    always @(posedge clk or posedge rst) begin
        if (rst) tcount <= 0;
        else     tcount <= tcount + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, tcount);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] r_req);
        int r;
        for (int k = 1; k <= ROWS; k++) begin
            r = (last + k) % ROWS;
            if (r_req[r*COLS +: COLS] != '0) return r;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   evt_valid,   0);
        check({tag, "_x"},       evt_x,       0);
        check({tag, "_y"},       evt_y,       0);
        check({tag, "_ts"},      evt_ts,      0);
        check({tag, "_ack"},     pix_ack,     0);
        check({tag, "_release"}, row_release, 0);
        check({tag, "_busy"},    busy,        0);
    endtask

    // Expects n_groups row groups; called at a negedge with the DUT idle and
    // requests already applied, so the first grant lands in the next cycle.
    task automatic run_groups(input int n_groups, input bit rand_ready,
                              input bit auto_clear, input int force_stall);
        int              grant;
        int              row;
        int              exp_valid;
        int              stalls;
        bit              first;
        int              cols[$];
        logic [TS_W-1:0] ts;
        grant = tcount + 1;
        first = 1'b1;
        for (int g = 0; g < n_groups; g++) begin
            row = rr_pick(m_last_row, req);
            if (row < 0) return;
            cols.delete();
            for (int c = 0; c < COLS; c++) begin
                if (req[row*COLS + c]) cols.push_back(c);
            end
            m_last_row = row;
            ts         = TS_W'(grant);
            exp_valid  = grant + 2;
            foreach (cols[i]) begin
                while (tcount < exp_valid) begin
                    cyc();
                    if (tcount < exp_valid) begin
                        check("gap_valid",   evt_valid,   0);
                        check("gap_ack",     pix_ack,     0);
                        check("gap_release", row_release, 0);
                    end
                end
                check("evt_valid", evt_valid, 1);
                check("evt_x",     evt_x,     cols[i]);
                check("evt_y",     evt_y,     row);
                check("evt_ts",    evt_ts,    ts);
                check("evt_busy",  busy,      1);
                stalls = 0;
                forever begin
                    if (first && force_stall > 0) ready = (stalls >= force_stall);
                    else if (rand_ready)          ready = (stalls >= 4) || ($urandom_range(0, 2) != 0);
                    else                          ready = 1'b1;
                    #1;
                    if (ready) break;
                    check("stall_ack", pix_ack, 0);
                    stalls++;
                    cyc();
                    check("hold_valid", evt_valid, 1);
                    check("hold_x",     evt_x,     cols[i]);
                    check("hold_y",     evt_y,     row);
                    check("hold_ts",    evt_ts,    ts);
                end
                check("ack", pix_ack, onehot(row*COLS + cols[i]));
                if (auto_clear) req[row*COLS + cols[i]] = 1'b0;
                exp_valid = tcount + 2;
                first     = 1'b0;
            end
            cyc();
            check("tail_valid",   evt_valid,   0);
            check("tail_release", row_release, 0);
            cyc();
            check("release",      row_release, 1);
            check("release_idle", busy,        0);
            grant = tcount + 1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) cyc();
        check_all_zero("reset");
        rst = 1'b0;
        m_last_row = ROWS - 1;
        en = 1'b1;

        // Single pixel at row 2, col 5.
        req[2*COLS + 5] = 1'b1;
        run_groups(1, 1'b0, 1'b1, 0);

        // Row 0 with columns 1, 3 and 6 in one group.
        req[0*COLS +: COLS] = 8'b0100_1010;
        run_groups(1, 1'b0, 1'b1, 0);

        // Backpressure: five stalled cycles on the first event.
        req[4*COLS + 2] = 1'b1;
        run_groups(1, 1'b0, 1'b1, 5);
`ifdef EBC_SEQ_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 5);
`endif

        // Enable dropped while an event is pending.
        req[1*COLS +: COLS] = 8'b0001_0101;
        ready = 1'b0;
        t0 = tcount;
        while (tcount < t0 + 3) cyc();
        check("dis_valid", evt_valid, 1);
        check("dis_x",     evt_x,     0);
        check("dis_y",     evt_y,     1);
        en = 1'b0;
        #1;
        check("dis_stall_ack", pix_ack, 0);
        cyc();
        check("dis_hold_valid", evt_valid, 1);
        check("dis_hold_busy",  busy,      1);
        ready = 1'b1;
        #1;
        check("dis_ack", pix_ack, onehot(1*COLS + 0));
        req[1*COLS + 0] = 1'b0;
        cyc();
        check("dis_idle",       busy,        0);
        check("dis_no_valid",   evt_valid,   0);
        check("dis_no_release", row_release, 0);
        cyc();
        check("dis_idle2",       busy,        0);
        check("dis_no_release2", row_release, 0);
        m_last_row = 1;
        en = 1'b1;
        run_groups(1, 1'b0, 1'b1, 0);

        // Reset asserted during EMIT.
        req[5*COLS +: COLS] = 8'b0000_0110;
        ready = 1'b0;
        t0 = tcount;
        while (tcount < t0 + 3) cyc();
        check("rst_pre_valid", evt_valid, 1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        cyc();
        check_all_zero("midrst_hold");
        rst = 1'b0;
        m_last_row = ROWS - 1;

        // Rows 0, 3, 7 requesting continuously: grants 0, 3, 7, 0.
        req = '0;
        req[0*COLS +: COLS] = 8'h11;
        req[3*COLS +: COLS] = 8'h80;
        req[7*COLS +: COLS] = 8'h03;
        run_groups(4, 1'b1, 1'b0, 0);
        req = '0;

        // Randomized request matrices with random backpressure.
        for (int r = 0; r < 24; r++) begin
            repeat ($urandom_range(0, 3)) cyc();
            rnd_req  = '0;
            rnd_rows = 0;
            for (int row = 0; row < ROWS; row++) begin
                if ($urandom_range(0, 1) == 1) begin
                    rnd_req[row*COLS +: COLS] = 8'($urandom_range(1, 255));
                    rnd_rows++;
                end
            end
            if (rnd_rows == 0) begin
                rnd_req[3*COLS +: COLS] = 8'h81;
                rnd_rows = 1;
            end
            req = rnd_req;
            run_groups(rnd_rows, 1'b1, 1'b1, 0);
        end

        cyc();
        check("final_idle", busy, 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
